soundweb_decoder: RTL and testbench
===================================

Name: soundweb_decoder

Overview:
Byte-serial receiver for the Soundweb London framed protocol. It is the receive-side counterpart of soundweb_encoder.
- Hunts for STX, removes ESC byte-stuffing, and accumulates the 13 body bytes (command, address_0..5, sv_0..1, data_0..3).
- Verifies the XOR checksum and the closing ETX.
- Presents the fields on registered outputs with a one-cycle valid pulse.
- Flags standalone ACK/NAK bytes and all framing, checksum and timeout faults.

Parameters:
TIMEOUT_CYCLES, 0, max clk cycles allowed between accepted bytes inside a frame; 0 disables the timeout
TIMEOUT_WIDTH, 16, width of the inter-byte timeout counter

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_byte is consumed on every clk edge where this is high; no backpressure
in_byte  input  8  raw wire byte
command  output  8  decoded command of last good packet
address_0..address_5  output  8 each  decoded address bytes of last good packet
sv_0..sv_1  output  8 each  decoded state-variable bytes of last good packet
data_0..data_3  output  8 each  decoded data bytes of last good packet
packet_valid  output  1  one-cycle pulse: field outputs were just updated
checksum_error  output  1  one-cycle pulse: ETX received but checksum mismatched
framing_error  output  1  one-cycle pulse: protocol violation, frame discarded
timeout_error  output  1  one-cycle pulse: inter-byte timeout, frame discarded
ack_received  output  1  one-cycle pulse: 0x06 received outside a frame
nak_received  output  1  one-cycle pulse: 0x15 received outside a frame

Behaviour:
- Constants: STX 0x02, ETX 0x03, ACK 0x06, NAK 0x15, ESC 0x1B. Reserved set = {02,03,06,15,1B}.
- Reset (async):
  - State = IDLE; byte count, XOR accumulator, shadow registers and timeout counter = 0.
  - All field outputs = 0x00; all pulse outputs = 0.
- Cycles with in_valid low: state is held; only the timeout counter advances.
- All pulse outputs are registered, asserted for exactly the cycle after the causing byte is sampled, and are mutually exclusive.
- States: IDLE, BODY, ESCAPE, WAIT_ETX.
- IDLE:
  - 02 -> BODY; clear count and XOR.
  - 06 -> ack_received pulse; 15 -> nak_received pulse.
  - Any other byte is ignored silently.
- BODY, handling of each raw byte b:
  - b = 1B -> ESCAPE.
  - b = 02 -> framing_error; restart frame (stay in BODY, count = 0, XOR = 0).
  - b in {03,06,15} -> framing_error -> IDLE.
  - Otherwise b is a decoded byte, handled by the decoded-byte rule below.
- ESCAPE, handling of raw byte r:
  - r in {82,83,86,95,9B} -> decoded byte = r - 0x80 (8-bit wrap); return to BODY or WAIT_ETX context via the decoded-byte rule.
  - r = 02 -> framing_error and restart as in BODY.
  - Any other r -> framing_error -> IDLE.
- Decoded-byte rule:
  - count 0..12: store into shadow[count] in order command, address_0..5, sv_0..1, data_0..3; XOR ^= byte; count++.
  - count 13: the byte is the checksum; latch match = (byte == XOR); -> WAIT_ETX.
- WAIT_ETX:
  - 03 with match -> copy all 13 shadows to the field outputs and pulse packet_valid; -> IDLE.
  - 03 without match -> checksum_error; field outputs unchanged; -> IDLE.
  - 02 -> framing_error and restart BODY.
  - Any other byte -> framing_error -> IDLE.
- Latency: field outputs and packet_valid update on the clk edge after the ETX edge, i.e. 1 cycle.
- Field outputs change only on packet_valid and otherwise hold the last good packet.
- Timeout (when TIMEOUT_CYCLES > 0):
  - The counter clears on every accepted byte and on entering IDLE.
  - It increments each cycle in BODY/ESCAPE/WAIT_ETX without in_valid.
  - When it reaches TIMEOUT_CYCLES -> timeout_error pulse -> IDLE.
  - The counter saturates and never wraps.
  - If in_valid is high on the cycle the limit is reached, the byte is processed and the timeout does not fire.
- Escaping applies to the checksum byte exactly as to body bytes.
- Mid-frame reset discards the partial frame with no pulse.

Test Plan:
- Good frame with escaped address: wire 02 88 10 1B 82 00 00 01 00 00 00 00 00 00 64 FF 03. Required: packet_valid 1 cycle after ETX; command=88, address_0..5=10,02,00,00,01,00, sv=00,00, data=00,00,00,64; no error pulses.
- Escaped checksum: same frame with data_3=98 and checksum sent as 1B 83 before 03. Required: packet_valid; data_3=98.
- Bad checksum: first frame with FF replaced by FE. Required: checksum_error pulse only; all field outputs keep their previous values.
- Standalone bytes in IDLE: 06, then 15, then 55. Required: ack_received pulse, then nak_received pulse, then nothing.
- Framing faults:
  - 02 88 03 -> framing_error, then IDLE.
  - 02 88 1B 41 -> framing_error, then IDLE.
  - 02 88 10 followed by a full good frame -> framing_error on the second 02, then packet_valid for the good frame.
- Timeout (TIMEOUT_CYCLES=8): 02 88, then in_valid low for 8 cycles -> timeout_error; a following good frame decodes normally. Reset asserted mid-frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/soundweb_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : soundweb_decoder
//  Purpose  : Byte-serial receiver for the Soundweb London framed protocol.
//             Hunts for STX, removes ESC byte-stuffing, collects the 13 body
//             bytes, checks XOR checksum and closing ETX, and reports the
//             decoded fields with single-cycle status pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module soundweb_decoder #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic [7:0] command,
    output logic [7:0] address_0,
    output logic [7:0] address_1,
    output logic [7:0] address_2,
    output logic [7:0] address_3,
    output logic [7:0] address_4,
    output logic [7:0] address_5,
    output logic [7:0] sv_0,
    output logic [7:0] sv_1,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       packet_valid,
    output logic       checksum_error,
    output logic       framing_error,
    output logic       timeout_error,
    output logic       ack_received,
    output logic       nak_received
);

    localparam logic [7:0] c_stx      = 8'h02;
    localparam logic [7:0] c_etx      = 8'h03;
    localparam logic [7:0] c_ack      = 8'h06;
    localparam logic [7:0] c_nak      = 8'h15;
    localparam logic [7:0] c_esc      = 8'h1B;
    localparam logic [7:0] c_esc_bias = 8'h80;
    localparam logic [3:0] c_body_len = 4'd13;
    localparam bit         c_timeout_en = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_WIDTH-1:0] c_timeout_limit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BODY     = 2'd1,
        S_ESCAPE   = 2'd2,
        S_WAIT_ETX = 2'd3
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_count;
    logic [7:0]               r_xor;
    logic [7:0]               r_shadow [0:12];
    logic                     r_match;
    logic [TIMEOUT_WIDTH-1:0] r_timer;

    logic                     w_is_reserved;
    logic                     w_esc_ok;
    logic                     w_dec_valid;
    logic [7:0]               w_dec_byte;
    logic [TIMEOUT_WIDTH-1:0] w_timer_inc;

    // Classify the incoming raw byte and produce the de-stuffed payload byte.
    always_comb begin
        w_is_reserved = (in_byte == c_stx) || (in_byte == c_etx) || (in_byte == c_ack) ||
                        (in_byte == c_nak) || (in_byte == c_esc);
        w_esc_ok      = (in_byte == 8'h82) || (in_byte == 8'h83) || (in_byte == 8'h86) ||
                        (in_byte == 8'h95) || (in_byte == 8'h9B);
        w_dec_byte    = (r_state == S_ESCAPE) ? (in_byte - c_esc_bias) : in_byte;
        w_dec_valid   = ((r_state == S_BODY) && !w_is_reserved) ||
                        ((r_state == S_ESCAPE) && w_esc_ok);
        // Saturating increment so a stalled link never wraps the counter.
        w_timer_inc   = (r_timer == '1) ? r_timer : (r_timer + 1'b1);
    end

    // Frame receiver: state, accumulation, output registers and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_xor          <= '0;
            r_match        <= 1'b0;
            r_timer        <= '0;
            for (int i = 0; i < 13; i++) begin
                r_shadow[i] <= '0;
            end
            command        <= '0;
            address_0      <= '0;
            address_1      <= '0;
            address_2      <= '0;
            address_3      <= '0;
            address_4      <= '0;
            address_5      <= '0;
            sv_0           <= '0;
            sv_1           <= '0;
            data_0         <= '0;
            data_1         <= '0;
            data_2         <= '0;
            data_3         <= '0;
            packet_valid   <= 1'b0;
            checksum_error <= 1'b0;
            framing_error  <= 1'b0;
            timeout_error  <= 1'b0;
            ack_received   <= 1'b0;
            nak_received   <= 1'b0;
        end else begin
            packet_valid   <= 1'b0;
            checksum_error <= 1'b0;
            framing_error  <= 1'b0;
            timeout_error  <= 1'b0;
            ack_received   <= 1'b0;
            nak_received   <= 1'b0;

            if (in_valid) begin
                r_timer <= '0;
                if (w_dec_valid) begin
                    // Payload byte: body bytes are stored, the 14th is the checksum.
                    if (r_count < c_body_len) begin
                        r_shadow[r_count] <= w_dec_byte;
                        r_xor             <= r_xor ^ w_dec_byte;
                        r_count           <= r_count + 4'd1;
                        r_state           <= S_BODY;
                    end else begin
                        r_match <= (w_dec_byte == r_xor);
                        r_state <= S_WAIT_ETX;
                    end
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (in_byte == c_stx) begin
                                r_state <= S_BODY;
                                r_count <= '0;
                                r_xor   <= '0;
                            end else if (in_byte == c_ack) begin
                                ack_received <= 1'b1;
                            end else if (in_byte == c_nak) begin
                                nak_received <= 1'b1;
                            end
                        end
                        S_WAIT_ETX: begin
                            if (in_byte == c_etx) begin
                                if (r_match) begin
                                    command      <= r_shadow[0];
                                    address_0    <= r_shadow[1];
                                    address_1    <= r_shadow[2];
                                    address_2    <= r_shadow[3];
                                    address_3    <= r_shadow[4];
                                    address_4    <= r_shadow[5];
                                    address_5    <= r_shadow[6];
                                    sv_0         <= r_shadow[7];
                                    sv_1         <= r_shadow[8];
                                    data_0       <= r_shadow[9];
                                    data_1       <= r_shadow[10];
                                    data_2       <= r_shadow[11];
                                    data_3       <= r_shadow[12];
                                    packet_valid <= 1'b1;
                                end else begin
                                    checksum_error <= 1'b1;
                                end
                                r_state <= S_IDLE;
                            end else if (in_byte == c_stx) begin
                                framing_error <= 1'b1;
                                r_state       <= S_BODY;
                                r_count       <= '0;
                                r_xor         <= '0;
                            end else begin
                                framing_error <= 1'b1;
                                r_state       <= S_IDLE;
                            end
                        end
                        default: begin
                            // BODY or ESCAPE with a non-payload byte.
                            if ((r_state == S_BODY) && (in_byte == c_esc)) begin
                                r_state <= S_ESCAPE;
                            end else if (in_byte == c_stx) begin
                                framing_error <= 1'b1;
                                r_state       <= S_BODY;
                                r_count       <= '0;
                                r_xor         <= '0;
                            end else begin
                                framing_error <= 1'b1;
                                r_state       <= S_IDLE;
                            end
                        end
                    endcase
                end
            end else if (c_timeout_en && (r_state != S_IDLE)) begin
                // Idle cycle inside a frame: age the frame and abandon it at the limit.
                if (w_timer_inc >= c_timeout_limit) begin
                    timeout_error <= 1'b1;
                    r_state       <= S_IDLE;
                    r_timer       <= '0;
                end else begin
                    r_timer <= w_timer_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soundweb_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soundweb_decoder
//  Purpose  : Self-checking scoreboard bench for soundweb_decoder. Directed
//             frames from the test plan followed by randomized transactions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_soundweb_decoder;

    localparam int TO = 8;
    localparam int K_PKT = 0, K_CKS = 1, K_FRM = 2, K_TMO = 3, K_ACK = 4, K_NAK = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_byte;
    logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
    logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
    logic       packet_valid, checksum_error, framing_error, timeout_error, ack_received, nak_received;

    soundweb_decoder #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .command(command), .address_0(address_0), .address_1(address_1),
        .address_2(address_2), .address_3(address_3), .address_4(address_4),
        .address_5(address_5), .sv_0(sv_0), .sv_1(sv_1), .data_0(data_0),
        .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .packet_valid(packet_valid), .checksum_error(checksum_error),
        .framing_error(framing_error), .timeout_error(timeout_error),
        .ack_received(ack_received), .nak_received(nak_received)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [103:0] dut_f;
    logic [5:0]   dut_p;
    assign dut_f = {command, address_0, address_1, address_2, address_3, address_4, address_5,
                    sv_0, sv_1, data_0, data_1, data_2, data_3};
    assign dut_p = {nak_received, ack_received, timeout_error, framing_error, checksum_error, packet_valid};

    typedef struct {
        int           kind;
        int           cyc;
        logic [103:0] f;
    } ev_t;

    ev_t          sb[$];
    logic [103:0] last_good = '0;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           last_cyc = 0;
    int           gap_max  = 3;
    logic [7:0]   body [13];
    logic [7:0]   cks;

    // ---------------- driver helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        last_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            last_cyc = cyc + 1;
        end
    endtask

    task automatic fsend(input logic [7:0] b);
        idle($urandom_range(0, gap_max));
        send(b);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = last_cyc;
        e.f    = last_good;
        sb.push_back(e);
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic bit is_rsv(input logic [7:0] b);
        return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) || (b == 8'h15) || (b == 8'h1B);
    endfunction

    function automatic bit is_esc_code(input logic [7:0] b);
        return (b == 8'h82) || (b == 8'h83) || (b == 8'h86) || (b == 8'h95) || (b == 8'h9B);
    endfunction

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0: return 8'h02;
                1: return 8'h03;
                2: return 8'h06;
                3: return 8'h15;
                default: return 8'h1B;
            endcase
        end
        return 8'($urandom);
    endfunction

    task automatic gen_body();
        cks = 8'h00;
        for (int i = 0; i < 13; i++) begin
            body[i] = rnd_byte();
            cks     = cks ^ body[i];
        end
    endtask

    function automatic logic [103:0] pack_body();
        logic [103:0] f = '0;
        for (int i = 0; i < 13; i++) f = {f[95:0], body[i]};
        return f;
    endfunction

    // Sends one payload byte with byte stuffing applied where needed.
    task automatic send_unit(input logic [7:0] b);
        if (is_rsv(b)) begin
            fsend(8'h1B);
            fsend(b + 8'h80);
        end else begin
            fsend(b);
        end
    endtask

    // Units 0..12 are body bytes, unit 13 is the checksum.
    task automatic send_units(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_unit((i < 13) ? body[i] : cks);
    endtask

    task automatic good_frame();
        gen_body();
        fsend(8'h02);
        send_units(0, 14);
        fsend(8'h03);
        last_good = pack_body();
        expect_ev(K_PKT);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && dut_p != 6'd0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got pulses=%b at cyc %0d, expected none", dut_p, cyc);
                end else begin
                    e = sb.pop_front();
                    if (dut_p != 6'(1 << e.kind) || cyc != e.cyc || dut_f !== e.f) begin
                        n_fail++;
                        $display("FAIL event: got pulses=%b cyc=%0d fields=%h, expected pulses=%b cyc=%0d fields=%h",
                                 dut_p, cyc, dut_f, 6'(1 << e.kind), e.cyc, e.f);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] f1[$];
        logic [7:0] f2[$];
        logic [7:0] fb[$];
        logic [7:0] b;
        int         k;
        f1 = '{8'h02, 8'h88, 8'h10, 8'h1B, 8'h82, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'hFF, 8'h03};
        f2 = '{8'h02, 8'h88, 8'h10, 8'h1B, 8'h82, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h98, 8'h1B, 8'h83, 8'h03};
        fb = f1;
        fb[15] = 8'hFE;

        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        idle(3);
        chk("reset_fields", dut_f, '0);
        chk("reset_pulses", {98'd0, dut_p}, '0);
        reset = 1'b0;
        idle(2);

        // Good frame with escaped address byte.
        send_list(f1);
        last_good = 104'h88_10_02_00_00_01_00_00_00_00_00_00_64;
        expect_ev(K_PKT);
        idle(2);
        // Escaped checksum.
        send_list(f2);
        last_good = 104'h88_10_02_00_00_01_00_00_00_00_00_00_98;
        expect_ev(K_PKT);
        idle(2);
        // Bad checksum keeps the previous fields.
        send_list(fb);
        expect_ev(K_CKS);
        idle(2);
        // Standalone bytes.
        send(8'h06); expect_ev(K_ACK);
        send(8'h15); expect_ev(K_NAK);
        send(8'h55);
        idle(2);
        // Framing faults.
        send(8'h02); send(8'h88); send(8'h03); expect_ev(K_FRM);
        idle(1);
        send(8'h02); send(8'h88); send(8'h1B); send(8'h41); expect_ev(K_FRM);
        idle(1);
        send(8'h02); send(8'h88); send(8'h10);
        send(f1[0]); expect_ev(K_FRM);
        for (int i = 1; i < f1.size(); i++) send(f1[i]);
        last_good = 104'h88_10_02_00_00_01_00_00_00_00_00_00_64;
        expect_ev(K_PKT);
        idle(2);
        // Timeout after exactly TO idle cycles, then normal decode.
        send(8'h02); send(8'h88);
        idle(TO);
        expect_ev(K_TMO);
        send_list(f1);
        expect_ev(K_PKT);
        idle(2);

        // Randomized transactions.
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 8))
                0: good_frame();
                1: begin // corrupted checksum
                    gen_body();
                    cks = cks ^ 8'($urandom_range(1, 255));
                    fsend(8'h02); send_units(0, 14); fsend(8'h03);
                    expect_ev(K_CKS);
                end
                2: begin // standalone byte in IDLE
                    case ($urandom_range(0, 2))
                        0: b = 8'h06;
                        1: b = 8'h15;
                        default: begin
                            b = 8'($urandom);
                            if (b == 8'h02 || b == 8'h06 || b == 8'h15) b = 8'h55;
                        end
                    endcase
                    send(b);
                    if (b == 8'h06) expect_ev(K_ACK);
                    if (b == 8'h15) expect_ev(K_NAK);
                end
                3: begin // illegal control byte in body
                    gen_body(); k = $urandom_range(0, 13);
                    fsend(8'h02); send_units(0, k);
                    case ($urandom_range(0, 2))
                        0: fsend(8'h03);
                        1: fsend(8'h06);
                        default: fsend(8'h15);
                    endcase
                    expect_ev(K_FRM);
                end
                4: begin // bad escape code
                    gen_body(); k = $urandom_range(0, 13);
                    fsend(8'h02); send_units(0, k); fsend(8'h1B);
                    do b = 8'($urandom); while (is_esc_code(b) || b == 8'h02);
                    fsend(b);
                    expect_ev(K_FRM);
                end
                5: begin // STX restart from any point, then a good frame
                    gen_body(); k = $urandom_range(0, 14);
                    fsend(8'h02); send_units(0, k);
                    if (k < 14 && $urandom_range(0, 3) == 0) fsend(8'h1B);
                    gen_body();
                    fsend(8'h02); expect_ev(K_FRM);
                    send_units(0, 14); fsend(8'h03);
                    last_good = pack_body();
                    expect_ev(K_PKT);
                end
                6: begin // wrong byte where ETX belongs
                    gen_body();
                    fsend(8'h02); send_units(0, 14);
                    do b = 8'($urandom); while (b == 8'h03 || b == 8'h02);
                    fsend(b);
                    expect_ev(K_FRM);
                end
                7: begin // timeout from any in-frame state
                    gen_body(); k = $urandom_range(0, 14);
                    fsend(8'h02); send_units(0, k);
                    if (k < 14 && $urandom_range(0, 1) == 1) fsend(8'h1B);
                    idle(TO);
                    expect_ev(K_TMO);
                end
                default: begin // longest legal gap does not time out
                    gen_body(); k = $urandom_range(0, 14);
                    fsend(8'h02); send_units(0, k);
                    idle(TO - 1);
                    gap_max = 0;
                    send_units(k, 14); fsend(8'h03);
                    gap_max = 3;
                    last_good = pack_body();
                    expect_ev(K_PKT);
                end
            endcase
            idle($urandom_range(1, 4));
        end

        // Mid-frame reset: everything clears with no pulse.
        send(8'h02); send(8'h88); send(8'h10);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        idle(2);
        chk("midreset_fields", dut_f, '0);
        chk("midreset_pulses", {98'd0, dut_p}, '0);
        reset = 1'b0;
        last_good = '0;
        idle(1);
        good_frame();
        idle(3);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 104'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
